// File: rtl/orange_zone_classifier_if.sv
// Pixel-stream and decision handshake bundle for orange_zone_classifier.
// Master drives pixels/ready; slave (the classifier) drives the decision outputs.
`timescale 1ns/1ps
interface orange_zone_classifier_if #(
  parameter int NUM_ZONES = 3,
  parameter int CNT_W     = 16
);
  localparam int ZIW = $clog2(NUM_ZONES);

  logic                       vsync;
  logic                       href;
  logic                       pix_en;
  logic                       is_orange;
  logic                       fast;
  logic                       orange_detected;
  logic [ZIW-1:0]             best_zone;
  logic [2:0]                 direction;
  logic                       result_valid;
  logic                       result_ready;
  logic                       overrun;
  logic [NUM_ZONES*CNT_W-1:0] zone_counts;

  modport master (
    output vsync, href, pix_en, is_orange, fast, result_ready,
    input  orange_detected, best_zone, direction, result_valid, overrun, zone_counts
  );

  modport slave (
    input  vsync, href, pix_en, is_orange, fast, result_ready,
    output orange_detected, best_zone, direction, result_valid, overrun, zone_counts
  );
endinterface

// File: rtl/orange_zone_classifier.sv
// Per-zone orange pixel histogram over a line window with argmax steering decision.
// ORANGE_ZONE_HIST_EN defined: zone_counts snapshot registered with each decision.
`timescale 1ns/1ps
module orange_zone_classifier #(
  parameter int NUM_ZONES          = 3,
  parameter int LINE_WIDTH         = 320,
  parameter int LINES_PER_DECISION = 1,
  parameter int CNT_W              = 16,
  parameter int MIN_PIXELS         = 8
) (
  input logic                    clk,
  input logic                    reset,
  orange_zone_classifier_if.slave bus
);
  localparam int ZW  = LINE_WIDTH / NUM_ZONES;
  localparam int ZIW = $clog2(NUM_ZONES);
  localparam int PIW = $clog2(LINE_WIDTH + 1);
  localparam int ZPW = $clog2(ZW + 1);
  localparam int LCW = (LINES_PER_DECISION > 1) ? $clog2(LINES_PER_DECISION) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ZIW-1:0]   CENTRE  = ZIW'(NUM_ZONES / 2);
  localparam logic [ZIW-1:0]   LAST    = ZIW'(NUM_ZONES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EVAL, S_UPDATE} state_e;

  state_e           state_q, state_d;
  logic             href_q;
  logic [PIW-1:0]   pix_q, pix_d;
  logic [ZPW-1:0]   zpos_q, zpos_d;
  logic [ZIW-1:0]   zone_q, zone_d;
  logic [LCW-1:0]   line_q, line_d;
  logic [CNT_W-1:0] acc_q [NUM_ZONES];
  logic [CNT_W-1:0] acc_d [NUM_ZONES];
  logic [ZIW-1:0]   eval_q, eval_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [ZIW-1:0]   best_q, best_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             det_q, det_d;
  logic [ZIW-1:0]   bz_q, bz_d;
  logic [2:0]       dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cur;
  logic             upd;

`ifdef ORANGE_ZONE_HIST_EN
  logic [NUM_ZONES*CNT_W-1:0] hist_q, hist_d;
`endif

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    zpos_d  = zpos_q;
    zone_d  = zone_q;
    line_d  = line_q;
    acc_d   = acc_q;
    eval_d  = eval_q;
    max_d   = max_q;
    best_d  = best_q;
    total_d = total_q;
    det_d   = det_q;
    bz_d    = bz_q;
    dir_d   = dir_q;
    upd     = 1'b0;
    cur     = acc_q[eval_q];
    sum     = {1'b0, total_q} + {1'b0, cur};
`ifdef ORANGE_ZONE_HIST_EN
    hist_d  = hist_q;
`endif

    if (bus.vsync) begin
      state_d = S_IDLE;
      line_d  = '0;
      for (int unsigned i = 0; i < NUM_ZONES; i++) acc_d[i] = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Edge-triggered entry skips a line already in progress.
          if (bus.href && !href_q) begin
            state_d = S_ACTIVE;
            pix_d   = '0;
            zpos_d  = '0;
            zone_d  = '0;
          end
        end
        S_ACTIVE: begin
          if (!bus.href) begin
            if (line_q == LCW'(LINES_PER_DECISION - 1)) begin
              state_d = S_EVAL;
              line_d  = '0;
              eval_d  = '0;
            end else begin
              state_d = S_IDLE;
              line_d  = line_q + 1'b1;
            end
          end else if (bus.pix_en && pix_q < PIW'(LINE_WIDTH)) begin
            if (bus.is_orange && acc_q[zone_q] != CNT_MAX)
              acc_d[zone_q] = acc_q[zone_q] + 1'b1;
            pix_d = pix_q + 1'b1;
            // The last zone never advances, so it absorbs the remainder pixels.
            if (zone_q != LAST) begin
              if (zpos_q == ZPW'(ZW - 1)) begin
                zone_d = zone_q + 1'b1;
                zpos_d = '0;
              end else begin
                zpos_d = zpos_q + 1'b1;
              end
            end
          end
        end
        S_EVAL: begin
          if (eval_q == '0) begin
            max_d   = cur;
            best_d  = '0;
            total_d = cur;
          end else begin
            if (cur > max_q) begin
              max_d  = cur;
              best_d = eval_q;
            end
            total_d = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
          end
          if (eval_q == LAST) state_d = S_UPDATE;
          else                eval_d  = eval_q + 1'b1;
        end
        S_UPDATE: begin
          upd     = 1'b1;
          state_d = S_IDLE;
          if (int'(total_q) < MIN_PIXELS) begin
            det_d = 1'b0;
            bz_d  = '0;
            dir_d = 3'd0;
          end else begin
            det_d = 1'b1;
            bz_d  = best_q;
            if (best_q < CENTRE)      dir_d = 3'd1;
            else if (best_q > CENTRE) dir_d = 3'd2;
            else                      dir_d = bus.fast ? 3'd3 : 3'd4;
          end
`ifdef ORANGE_ZONE_HIST_EN
          for (int unsigned i = 0; i < NUM_ZONES; i++)
            hist_d[i*CNT_W +: CNT_W] = acc_q[i];
`endif
          for (int unsigned i = 0; i < NUM_ZONES; i++) acc_d[i] = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    valid_d = valid_q;
    if (valid_q && bus.result_ready) valid_d = 1'b0;
    if (upd) valid_d = 1'b1;
    ovr_d = upd && valid_q && !bus.result_ready;
  end

  always_ff @(posedge clk) begin
    href_q <= bus.href;
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      zpos_q  <= '0;
      zone_q  <= '0;
      line_q  <= '0;
      acc_q   <= '{default: '0};
      eval_q  <= '0;
      max_q   <= '0;
      best_q  <= '0;
      total_q <= '0;
      det_q   <= 1'b0;
      bz_q    <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef ORANGE_ZONE_HIST_EN
      hist_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      zpos_q  <= zpos_d;
      zone_q  <= zone_d;
      line_q  <= line_d;
      acc_q   <= acc_d;
      eval_q  <= eval_d;
      max_q   <= max_d;
      best_q  <= best_d;
      total_q <= total_d;
      det_q   <= det_d;
      bz_q    <= bz_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef ORANGE_ZONE_HIST_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign bus.orange_detected = det_q;
  assign bus.best_zone       = bz_q;
  assign bus.direction       = dir_q;
  assign bus.result_valid    = valid_q;
  assign bus.overrun         = ovr_q;
`ifdef ORANGE_ZONE_HIST_EN
  assign bus.zone_counts     = hist_q;
`else
  assign bus.zone_counts     = '0;
`endif
endmodule
